// File: rtl/sdram_read_arbiter.sv
// Two-master round-robin read arbiter onto one bursting Avalon-MM SDRAM port.
// In-order tag FIFO steers returning beats to the master that issued the burst.
module sdram_read_arbiter #(
  parameter int ADDR_W    = 27,
  parameter int BC_W      = 8,
  parameter int DATA_W    = 256,
  parameter int TAG_DEPTH = 4
) (
  input  logic                         CLOCK,
  input  logic                         reset_n,
  input  logic [ADDR_W-1:0]            m0_address,
  input  logic [BC_W-1:0]              m0_burstcount,
  input  logic                         m0_read,
  output logic                         m0_waitrequest,
  output logic [DATA_W-1:0]            m0_readdata,
  output logic                         m0_readdatavalid,
  input  logic [ADDR_W-1:0]            m1_address,
  input  logic [BC_W-1:0]              m1_burstcount,
  input  logic                         m1_read,
  output logic                         m1_waitrequest,
  output logic [DATA_W-1:0]            m1_readdata,
  output logic                         m1_readdatavalid,
  output logic [ADDR_W-1:0]            sdram_address,
  output logic [BC_W-1:0]              sdram_burstcount,
  output logic                         sdram_read,
  input  logic                         sdram_waitrequest,
  input  logic [DATA_W-1:0]            sdram_readdata,
  input  logic                         sdram_readdatavalid,
  output logic [$clog2(TAG_DEPTH):0]   outstanding,
  output logic                         err_orphan
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  logic              r_sd_read;
  logic [ADDR_W-1:0] r_sd_addr;
  logic [BC_W-1:0]   r_sd_bc;
  logic              r_last_grant;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_wr;
  logic [PW-1:0]     r_rd;
  logic [BC_W-1:0]   r_beat;
  logic              r_err;
  logic              r_m0_rdv;
  logic              r_m1_rdv;
  logic [DATA_W-1:0] r_m0_data;
  logic [DATA_W-1:0] r_m1_data;

  logic              r_own [TAG_DEPTH];
  logic [BC_W-1:0]   r_bc  [TAG_DEPTH];

  logic              w_can_accept;
  logic              w_gnt1;
  logic              w_accept;
  logic [ADDR_W-1:0] w_addr;
  logic [BC_W-1:0]   w_bc;
  logic              w_push;
  logic              w_empty;
  logic              w_head_own;
  logic [BC_W-1:0]   w_head_bc;
  logic              w_beat;
  logic              w_pop;

  assign w_can_accept = !r_sd_read && (r_count != CW'(TAG_DEPTH));
  // On a tie the grant goes to whoever did not win last time
  assign w_gnt1   = (m0_read && m1_read) ? !r_last_grant : m1_read;
  assign w_accept = w_can_accept && (m0_read || m1_read);
  assign w_addr   = w_gnt1 ? m1_address : m0_address;
  assign w_bc     = w_gnt1 ? m1_burstcount : m0_burstcount;
  assign w_push   = w_accept && (w_bc != '0);

  assign m0_waitrequest = !(w_accept && !w_gnt1);
  assign m1_waitrequest = !(w_accept && w_gnt1);

  assign w_empty    = (r_count == '0);
  assign w_head_own = r_own[r_rd];
  assign w_head_bc  = r_bc[r_rd];
  assign w_beat     = sdram_readdatavalid && !w_empty;
  assign w_pop      = w_beat && (r_beat == w_head_bc - BC_W'(1));

  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      r_sd_read    <= 1'b0;
      r_sd_addr    <= '0;
      r_sd_bc      <= '0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_accept)
        r_last_grant <= w_gnt1;
      if (w_push) begin
        r_sd_read <= 1'b1;
        r_sd_addr <= w_addr;
        r_sd_bc   <= w_bc;
      end else if (r_sd_read && !sdram_waitrequest) begin
        r_sd_read <= 1'b0;
      end
    end
  end

  // Tag storage is only read while non-empty, so it needs no reset
  always_ff @(posedge CLOCK) begin
    if (w_push) begin
      r_own[r_wr] <= w_gnt1;
      r_bc[r_wr]  <= w_bc;
    end
  end

  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_beat  <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        r_rd   <= r_rd + 1'b1;
        r_beat <= '0;
      end else if (w_beat) begin
        r_beat <= r_beat + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      r_m0_rdv  <= 1'b0;
      r_m1_rdv  <= 1'b0;
      r_m0_data <= '0;
      r_m1_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_m0_rdv <= w_beat && !w_head_own;
      r_m1_rdv <= w_beat && w_head_own;
      if (w_beat && !w_head_own)
        r_m0_data <= sdram_readdata;
      if (w_beat && w_head_own)
        r_m1_data <= sdram_readdata;
      if (sdram_readdatavalid && w_empty)
        r_err <= 1'b1;
    end
  end

  assign sdram_read       = r_sd_read;
  assign sdram_address    = r_sd_addr;
  assign sdram_burstcount = r_sd_bc;
  assign outstanding      = r_count;
  assign err_orphan       = r_err;
  assign m0_readdatavalid = r_m0_rdv;
  assign m1_readdatavalid = r_m1_rdv;
  assign m0_readdata      = r_m0_data;
  assign m1_readdata      = r_m1_data;

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Directed vector bench for sdram_read_arbiter.
// Table rows cover routing/arbitration; hand sequences cover full FIFO, orphans, reset.
module tb_sdram_read_arbiter;

  localparam int ADDR_W = 27;
  localparam int BC_W   = 8;
  localparam int DATA_W = 256;
  localparam int TD     = 4;

  logic              CLOCK = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] m0_address = '0;
  logic [BC_W-1:0]   m0_burstcount = '0;
  logic              m0_read = 1'b0;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;
  logic [ADDR_W-1:0] m1_address = '0;
  logic [BC_W-1:0]   m1_burstcount = '0;
  logic              m1_read = 1'b0;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;
  logic [ADDR_W-1:0] sdram_address;
  logic [BC_W-1:0]   sdram_burstcount;
  logic              sdram_read;
  logic              sdram_waitrequest = 1'b0;
  logic [DATA_W-1:0] sdram_readdata = '0;
  logic              sdram_readdatavalid = 1'b0;
  logic [2:0]        outstanding;
  logic              err_orphan;

  sdram_read_arbiter #(
    .ADDR_W(ADDR_W), .BC_W(BC_W), .DATA_W(DATA_W), .TAG_DEPTH(TD)
  ) dut (
    .CLOCK(CLOCK), .reset_n(reset_n),
    .m0_address(m0_address), .m0_burstcount(m0_burstcount),
    .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_burstcount(m1_burstcount),
    .m1_read(m1_read), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .sdram_address(sdram_address), .sdram_burstcount(sdram_burstcount),
    .sdram_read(sdram_read), .sdram_waitrequest(sdram_waitrequest),
    .sdram_readdata(sdram_readdata),
    .sdram_readdatavalid(sdram_readdatavalid),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 CLOCK = ~CLOCK;

  // inputs: rst r0 a0 b0 r1 a1 b1 sw sv sd | expected outputs for that cycle
  typedef struct {
    int rst; int r0; int a0; int b0; int r1; int a1; int b1;
    int sw; int sv; int sd;
    int w0; int w1; int srd; int sa; int sb;
    int v0; int v1; int d0; int d1; int out; int err;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic rst_pulse();
    m0_read = 1'b0;
    m1_read = 1'b0;
    sdram_waitrequest = 1'b0;
    sdram_readdatavalid = 1'b0;
    reset_n = 1'b0;
    @(posedge CLOCK);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic chk(string nm, longint got, longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic apply(int idx, vec_t v);
    bit ok;
    if (v.rst != 0) rst_pulse();
    m0_read = v.r0[0];
    m0_address = ADDR_W'(v.a0);
    m0_burstcount = BC_W'(v.b0);
    m1_read = v.r1[0];
    m1_address = ADDR_W'(v.a1);
    m1_burstcount = BC_W'(v.b1);
    sdram_waitrequest = v.sw[0];
    sdram_readdatavalid = v.sv[0];
    sdram_readdata = DATA_W'(v.sd);
    #1;
    ok = (int'(m0_waitrequest) == v.w0) && (int'(m1_waitrequest) == v.w1)
      && (int'(sdram_read) == v.srd) && (int'(sdram_address) == v.sa)
      && (int'(sdram_burstcount) == v.sb)
      && (int'(m0_readdatavalid) == v.v0) && (int'(m1_readdatavalid) == v.v1)
      && (m0_readdata == DATA_W'(v.d0)) && (m1_readdata == DATA_W'(v.d1))
      && (int'(outstanding) == v.out) && (int'(err_orphan) == v.err);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL vec%0d got w=%b%b rd=%b a=%h bc=%0d v=%b%b d0=%h d1=%h out=%0d err=%b want w=%0d%0d rd=%0d a=%h bc=%0d v=%0d%0d d0=%h d1=%h out=%0d err=%0d",
        idx, m0_waitrequest, m1_waitrequest, sdram_read, sdram_address,
        sdram_burstcount, m0_readdatavalid, m1_readdatavalid,
        m0_readdata[31:0], m1_readdata[31:0], outstanding, err_orphan,
        v.w0, v.w1, v.srd, v.sa, v.sb, v.v0, v.v1, v.d0, v.d1, v.out, v.err);
    end
    step();
  endtask

  initial begin
    // single master, bc 4
    vq.push_back('{1,1,'h100,4,0,0,0,0,0,0,     0,1,0,0,0,0,0,0,0,0,0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0,         1,1,1,'h100,4,0,0,0,0,1,0});
    vq.push_back('{0,0,0,0,0,0,0,0,1,'hD0,      1,1,0,'h100,4,0,0,0,0,1,0});
    vq.push_back('{0,0,0,0,0,0,0,0,1,'hD1,      1,1,0,'h100,4,1,0,'hD0,0,1,0});
    vq.push_back('{0,0,0,0,0,0,0,0,1,'hD2,      1,1,0,'h100,4,1,0,'hD1,0,1,0});
    vq.push_back('{0,0,0,0,0,0,0,0,1,'hD3,      1,1,0,'h100,4,1,0,'hD2,0,1,0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0,         1,1,0,'h100,4,1,0,'hD3,0,0,0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0,         1,1,0,'h100,4,0,0,'hD3,0,0,0});
    // contention, bc 2 each, interleaved returns
    vq.push_back('{1,1,'h200,2,1,'h300,2,0,0,0,     0,1,0,0,0,0,0,0,0,0,0});
    vq.push_back('{0,1,'h200,2,1,'h300,2,0,0,0,     1,1,1,'h200,2,0,0,0,0,1,0});
    vq.push_back('{0,1,'h200,2,1,'h300,2,0,0,0,     1,0,0,'h200,2,0,0,0,0,1,0});
    vq.push_back('{0,1,'h200,2,1,'h300,2,0,1,'hA0,  1,1,1,'h300,2,0,0,0,0,2,0});
    vq.push_back('{0,1,'h200,2,1,'h300,2,0,1,'hA1,  0,1,0,'h300,2,1,0,'hA0,0,2,0});
    vq.push_back('{0,1,'h200,2,1,'h300,2,0,1,'hB0,  1,1,1,'h200,2,1,0,'hA1,0,2,0});
    vq.push_back('{0,1,'h200,2,1,'h300,2,0,1,'hB1,  1,0,0,'h200,2,0,1,'hA1,'hB0,2,0});
    vq.push_back('{0,0,0,0,0,0,0,0,1,'hC0,          1,1,1,'h300,2,0,1,'hA1,'hB1,2,0});
    vq.push_back('{0,0,0,0,0,0,0,0,1,'hC1,          1,1,0,'h300,2,1,0,'hC0,'hB1,2,0});
    vq.push_back('{0,0,0,0,0,0,0,0,1,'hE0,          1,1,0,'h300,2,1,0,'hC1,'hB1,1,0});
    vq.push_back('{0,0,0,0,0,0,0,0,1,'hE1,          1,1,0,'h300,2,0,1,'hC1,'hE0,1,0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0,             1,1,0,'h300,2,0,1,'hC1,'hE1,0,0});
    // slave backpressure for 5 cycles
    vq.push_back('{1,1,'h400,1,1,'h500,1,1,0,0,     0,1,0,0,0,0,0,0,0,0,0});
    for (int i = 0; i < 5; i++)
      vq.push_back('{0,1,'h400,1,1,'h500,1,1,0,0,   1,1,1,'h400,1,0,0,0,0,1,0});
    vq.push_back('{0,1,'h400,1,1,'h500,1,0,0,0,     1,1,1,'h400,1,0,0,0,0,1,0});
    vq.push_back('{0,1,'h400,1,1,'h500,1,0,0,0,     1,0,0,'h400,1,0,0,0,0,1,0});
    vq.push_back('{0,0,0,0,0,0,0,0,1,'h11,          1,1,1,'h500,1,0,0,0,0,2,0});
    vq.push_back('{0,0,0,0,0,0,0,0,1,'h22,          1,1,0,'h500,1,1,0,'h11,0,1,0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0,             1,1,0,'h500,1,0,1,'h11,'h22,0,0});

    #2;
    foreach (vq[i]) apply(i, vq[i]);

    // full tag FIFO: four bc-128 bursts, fifth waits for the first pop
    rst_pulse();
    m0_read = 1'b1;
    m0_burstcount = 8'd128;
    m0_address = 27'h600;
    for (int k = 0; k < 4; k++) begin
      #1 chk("full_acc", longint'(m0_waitrequest), 0);
      step();
      #1 chk("full_iss", longint'(sdram_read), 1);
      step();
    end
    #1 chk("full_cnt", longint'(outstanding), 4);
    chk("full_stall", longint'(m0_waitrequest), 1);
    step();
    sdram_readdatavalid = 1'b1;
    for (int i = 0; i < 128; i++) begin
      sdram_readdata = DATA_W'(i);
      if (i == 127) begin
        #1 chk("pop_cycle_stall", longint'(m0_waitrequest), 1);
      end
      step();
    end
    sdram_readdatavalid = 1'b0;
    #1 chk("after_pop_acc", longint'(m0_waitrequest), 0);
    chk("after_pop_cnt", longint'(outstanding), 3);
    chk("beat127", longint'(m0_readdata[63:0]), 127);
    step();
    m0_read = 1'b0;
    #1 chk("fifth_iss", longint'(sdram_read), 1);
    chk("fifth_cnt", longint'(outstanding), 4);

    // orphan beat, zero-length burst, async reset mid-burst
    rst_pulse();
    sdram_readdatavalid = 1'b1;
    sdram_readdata = DATA_W'(32'hBAD);
    #1 chk("orph_pre", longint'(err_orphan), 0);
    step();
    sdram_readdatavalid = 1'b0;
    #1 chk("orph_set", longint'(err_orphan), 1);
    chk("orph_nov", longint'({m0_readdatavalid, m1_readdatavalid}), 0);
    step();
    #1 chk("orph_sticky", longint'(err_orphan), 1);
    m0_read = 1'b1;
    m0_burstcount = 8'd0;
    m0_address = 27'h700;
    #1 chk("bc0_acc", longint'(m0_waitrequest), 0);
    step();
    m0_read = 1'b0;
    #1 chk("bc0_noiss", longint'(sdram_read), 0);
    chk("bc0_nopush", longint'(outstanding), 0);
    step();
    m0_read = 1'b1;
    m0_burstcount = 8'd1;
    m0_address = 27'h710;
    m1_read = 1'b1;
    m1_burstcount = 8'd2;
    m1_address = 27'h720;
    #1 chk("bc0_lastg", longint'({m0_waitrequest, m1_waitrequest}), 2);
    step();
    m0_read = 1'b0;
    m1_read = 1'b0;
    #1 chk("m1_iss_addr", longint'(sdram_address), 'h720);
    chk("m1_iss_cnt", longint'(outstanding), 1);
    step();
    sdram_readdatavalid = 1'b1;
    sdram_readdata = DATA_W'(32'h55);
    step();
    sdram_readdatavalid = 1'b0;
    #1 chk("m1_beat", longint'(m1_readdata[63:0]), 'h55);
    chk("m1_beat_v", longint'(m1_readdatavalid), 1);
    #2 reset_n = 1'b0;
    #1 chk("rst_err", longint'(err_orphan), 0);
    chk("rst_v", longint'(m1_readdatavalid), 0);
    chk("rst_data", longint'(m1_readdata[63:0]), 0);
    chk("rst_addr", longint'(sdram_address), 0);
    chk("rst_cnt", longint'(outstanding), 0);
    reset_n = 1'b1;
    sdram_readdatavalid = 1'b1;
    sdram_readdata = DATA_W'(32'h66);
    step();
    sdram_readdatavalid = 1'b0;
    #1 chk("inflight_orph", longint'(err_orphan), 1);
    chk("inflight_nov", longint'({m0_readdatavalid, m1_readdatavalid}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_read_arbiter.md
Name: sdram_read_arbiter

Overview:
- Shares one Avalon-MM bursting read port on SDRAM between two read masters, for example two memory burst processors or a burst processor plus a weight loader.
- Accepts one command at a time using round-robin arbitration and issues it through a registered command stage.
- Records each accepted command's owner and burst length in an in-order tag FIFO.
- Routes returning read beats to the owning master with one cycle of registered latency.

Parameters:
- ADDR_W, 27, address width on both sides.
- BC_W, 8, burstcount width.
- DATA_W, 256, read data width.
- TAG_DEPTH, 4, maximum bursts outstanding (power of 2, 2..16).

Ports:
- CLOCK  in  1  clock, all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- m0_address  in  ADDR_W  master 0 word address.
- m0_burstcount  in  BC_W  master 0 beats requested.
- m0_read  in  1  master 0 read request.
- m0_waitrequest  out  1  master 0 stall (combinational).
- m0_readdata  out  DATA_W  master 0 return data.
- m0_readdatavalid  out  1  master 0 beat valid.
- m1_address, m1_burstcount, m1_read, m1_waitrequest, m1_readdata, m1_readdatavalid: same as m0, for master 1.
- sdram_address  out  ADDR_W  issued address.
- sdram_burstcount  out  BC_W  issued burstcount.
- sdram_read  out  1  issued read strobe.
- sdram_waitrequest  in  1  slave stall.
- sdram_readdata  in  DATA_W  slave data.
- sdram_readdatavalid  in  1  slave beat valid.
- outstanding  out  log2(TAG_DEPTH)+1  bursts in the tag FIFO.
- err_orphan  out  1  sticky: a beat arrived while the tag FIFO was empty.

Behaviour:
- Reset values:
  - sdram_read=0, sdram_address=0, sdram_burstcount=0.
  - m*_readdatavalid=0, m*_readdata=0.
  - Tag FIFO empty, outstanding=0, err_orphan=0.
  - last_grant=1, so master 0 wins the first tie.
- can_accept = !sdram_read && (outstanding != TAG_DEPTH). It uses the registered sdram_read. A pop in the same cycle does not free space for a push.
- Grant, combinational:
  - If can_accept and exactly one mN_read is high, grant that master.
  - If both are high, grant the master != last_grant.
- mN_waitrequest = !(grant==N && can_accept). Waitrequest is high whenever the master is not granted, including while it is idle.
- On accept (rising edge):
  - Capture address and burstcount into the sdram_* registers and set sdram_read=1.
  - Push {owner, burstcount} to the tag FIFO.
  - Set last_grant to the owner.
- burstcount==0 is accepted, dropped, and last_grant updates. Nothing is issued and nothing is pushed.
- Command stage: sdram_read, address and burstcount are held stable while sdram_waitrequest=1. sdram_read clears on the first edge where sdram_waitrequest=0.
- Next accept: the earliest is the cycle after issue completes, giving a 2-cycle minimum spacing per command.
- Return path, on each sdram_readdatavalid:
  - If the FIFO is non-empty: on the next edge, drive the head owner's mN_readdata with the beat and pulse its mN_readdatavalid for 1 cycle. The other master's valid stays 0 and its data holds.
  - Increment beat_cnt, which has BC_W bits and resets to 0.
  - When beat_cnt == head.burstcount-1, pop the head and clear beat_cnt.
  - If the FIFO is empty: drop the beat and set err_orphan. err_orphan is cleared only by reset.
- A push and a pop in the same cycle leave outstanding unchanged. The FIFO pointers wrap modulo TAG_DEPTH.
- Beats from consecutive bursts arrive back-to-back with no gap. The pop and the next head switch take effect on the same edge.
- Reset mid-operation: all state clears immediately.
  - In-flight beats arriving after reset are orphans and set err_orphan.
  - The system must quiesce SDRAM before releasing reset.

Test Plan:
- Single master: m0 reads addr 0x100, bc 4. Expected response:
  - sdram_read rises 1 cycle after accept with address 0x100, bc 4.
  - 4 beats D0..D3 appear on m0 one cycle after each sdram valid.
  - m1_readdatavalid never asserts.
  - outstanding goes 0→1→0.
- Contention: m0 and m1 both hold read continuously with bc 2. Expected response:
  - Grants alternate m0, m1, m0, m1.
  - Returned beats route in the same order, 2 per master.
- Waitrequest backpressure: hold sdram_waitrequest=1 for 5 cycles during issue. Expected response:
  - sdram_* stay stable for all 5 cycles.
  - The other master's waitrequest stays high until sdram_read clears.
- FIFO full, TAG_DEPTH=4: issue 4 bursts of bc 128 with no data returned. Expected response:
  - The 5th request is stalled until the first beat-128 pop.
  - It is accepted on the following cycle, not the pop cycle.
- Back-to-back returns: m0 issues bc 1, then m1 issues bc 3, with 4 contiguous valid beats. Expected response: m0 gets beat 0 and m1 gets beats 1..3.
- Orphan and zero-length: inject sdram_readdatavalid with the FIFO empty, and issue m1 with bc 0. Expected response:
  - err_orphan=1 and stays set.
  - The bc 0 request is accepted in 1 cycle with no sdram_read.
  - Asserting reset_n=0 mid-burst clears err_orphan and all outputs asynchronously.
